// File: rtl/ht_reset_pkg.sv
// Shared types and default timing for the reset sequencer.
// Provides the FSM state encoding and a max helper used to size the counter.
package ht_reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  localparam int DEF_HOLD_CYC  = 16;
  localparam int DEF_STAGE_GAP = 4;
  localparam int DEF_DRAIN_TO  = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ht_reset_sync.sv
// Reset synchronizer: asserts asynchronously with i_reset and deasserts
// on the second clock edge after i_reset goes low.
module ht_reset_sync (
  input  logic clk,
  input  logic i_reset,
  output logic o_rst
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift of zeros out of a preset chain.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign o_rst = sync_q;

endmodule

// File: rtl/ht_reset_seq.sv
// Reset sequencer: holds all unit resets, releases them one by one with a fixed
// gap, and on a software reset drains the units before re-asserting.
module ht_reset_seq
  import ht_reset_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int STAGE_GAP = DEF_STAGE_GAP,
  parameter int DRAIN_TO  = DEF_DRAIN_TO
) (
  input  logic                 clk1x,
  input  logic                 i_reset,
  input  logic                 i_swReset,
  input  logic [NUM_UNITS-1:0] i_unitIdle,
  output logic [NUM_UNITS-1:0] r_unitReset,
  output logic                 r_ready,
  output logic                 r_busy,
  output logic                 r_timeout
);

  localparam int CNT_W = $clog2(max3(HOLD_CYC, STAGE_GAP, DRAIN_TO)) + 1;
  localparam int IDX_W = $clog2(NUM_UNITS + 1);

  logic rst_s;

  state_e               state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [IDX_W-1:0]     idx_q,     idx_d;
  logic [NUM_UNITS-1:0] unit_q,    unit_d;
  logic                 ready_q,   ready_d;
  logic                 busy_q,    busy_d;
  logic                 timeout_q, timeout_d;

  ht_reset_sync u_sync (
    .clk     (clk1x),
    .i_reset (i_reset),
    .o_rst   (rst_s)
  );

  // Next-state and output logic; counter compares are against N-1 because
  // the compare happens on the edge that would make the count reach N.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    unit_d    = unit_q;
    ready_d   = 1'b0;
    busy_d    = 1'b1;
    timeout_d = timeout_q;
    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          unit_d[0] = 1'b0;
          cnt_d     = '0;
          idx_d     = IDX_W'(1);
          state_d   = (NUM_UNITS == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          for (int i = 0; i < NUM_UNITS; i++) begin
            unit_d[i] = unit_q[i] & (idx_q != IDX_W'(i));
          end
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
          if (idx_q == IDX_W'(NUM_UNITS - 1)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (i_swReset) begin
          state_d   = ST_DRAIN;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Idle takes priority over a coincident timeout.
        if (&i_unitIdle) begin
          state_d = ST_ASSERT;
          unit_d  = {NUM_UNITS{1'b1}};
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CNT_W'(DRAIN_TO - 1)) begin
          state_d   = ST_ASSERT;
          unit_d    = {NUM_UNITS{1'b1}};
          cnt_d     = '0;
          idx_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_ASSERT;
        unit_d  = {NUM_UNITS{1'b1}};
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers, cleared by the synchronized reset.
  always_ff @(posedge clk1x or posedge rst_s) begin
    if (rst_s) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      unit_q    <= {NUM_UNITS{1'b1}};
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      unit_q    <= unit_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign r_unitReset = unit_q;
  assign r_ready     = ready_q;
  assign r_busy      = busy_q;
  assign r_timeout   = timeout_q;

endmodule

// File: tb/tb_ht_reset_seq.sv
// Directed bench for ht_reset_seq: power-on, software reset with and without
// drain timeout, idle/timeout coincidence, async reset mid-release, single unit.
module tb_ht_reset_seq;

  logic       clk1x = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_swReset = 1'b0;
  logic [3:0] i_unitIdle = 4'b1111;
  logic [3:0] r_unitReset;
  logic       r_ready, r_busy, r_timeout;

  logic       sw1 = 1'b0;
  logic [0:0] idle1 = 1'b1;
  logic [0:0] unit1;
  logic       ready1, busy1, timeout1;

  int checks = 0;
  int failures = 0;

  ht_reset_seq dut (
    .clk1x       (clk1x),
    .i_reset     (i_reset),
    .i_swReset   (i_swReset),
    .i_unitIdle  (i_unitIdle),
    .r_unitReset (r_unitReset),
    .r_ready     (r_ready),
    .r_busy      (r_busy),
    .r_timeout   (r_timeout)
  );

  ht_reset_seq #(.NUM_UNITS(1)) dut1 (
    .clk1x       (clk1x),
    .i_reset     (i_reset),
    .i_swReset   (sw1),
    .i_unitIdle  (idle1),
    .r_unitReset (unit1),
    .r_ready     (ready1),
    .r_busy      (busy1),
    .r_timeout   (timeout1)
  );

  always #5 clk1x = ~clk1x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk1x);
    #1;
  endtask

  function automatic logic [3:0] exp_units(input int e);
    if (e >= 28)      return 4'b0000;
    else if (e >= 24) return 4'b1000;
    else if (e >= 20) return 4'b1100;
    else if (e >= 16) return 4'b1110;
    else              return 4'b1111;
  endfunction

  // Walks edges 1..last_e after (re)assert; optionally pokes swReset in ASSERT/RELEASE.
  task automatic check_seq(input logic exp_to, input bit poke, input bit chk1, input int last_e);
    for (int e = 1; e <= last_e; e++) begin
      if (poke && (e == 5 || e == 18)) i_swReset = 1'b1;
      tick();
      i_swReset = 1'b0;
      chk($sformatf("units@%0d", e), 32'(r_unitReset), 32'(exp_units(e)));
      chk($sformatf("ready@%0d", e), 32'(r_ready), 32'(e >= 29));
      chk($sformatf("busy@%0d", e), 32'(r_busy), 32'(e < 29));
      chk($sformatf("timeout@%0d", e), 32'(r_timeout), 32'(exp_to));
      if (chk1) begin
        chk($sformatf("u1_unit@%0d", e), 32'(unit1), 32'(e < 16));
        chk($sformatf("u1_ready@%0d", e), 32'(ready1), 32'(e >= 17));
        chk($sformatf("u1_busy@%0d", e), 32'(busy1), 32'(e < 17));
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk1x);
    i_reset = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Power-on reset values
    #2 i_reset = 1'b1;
    repeat (5) tick();
    chk("rst_units", 32'(r_unitReset), 32'h0000000f);
    chk("rst_ready", 32'(r_ready), 32'd0);
    chk("rst_busy", 32'(r_busy), 32'd1);
    chk("rst_timeout", 32'(r_timeout), 32'd0);
    chk("rst_u1_unit", 32'(unit1), 32'd1);
    release_reset();
    check_seq(1'b0, 1'b0, 1'b1, 30);

    // Software reset with all units idle
    i_unitIdle = 4'b1111;
    i_swReset = 1'b1;
    tick();
    i_swReset = 1'b0;
    chk("sw_ready_S", 32'(r_ready), 32'd0);
    chk("sw_busy_S", 32'(r_busy), 32'd1);
    chk("sw_units_S", 32'(r_unitReset), 32'h0);
    tick();
    chk("sw_units_S1", 32'(r_unitReset), 32'hf);
    chk("sw_timeout_S1", 32'(r_timeout), 32'd0);
    check_seq(1'b0, 1'b0, 1'b0, 30);

    // Drain timeout, with an ignored pulse inside DRAIN
    i_unitIdle = 4'b0111;
    i_swReset = 1'b1;
    tick();
    i_swReset = 1'b0;
    chk("to_ready_S", 32'(r_ready), 32'd0);
    for (int k = 1; k <= 63; k++) begin
      if (k == 10) i_swReset = 1'b1;
      tick();
      i_swReset = 1'b0;
    end
    chk("to_units_S63", 32'(r_unitReset), 32'h0);
    chk("to_timeout_S63", 32'(r_timeout), 32'd0);
    tick();
    chk("to_units_S64", 32'(r_unitReset), 32'hf);
    chk("to_timeout_S64", 32'(r_timeout), 32'd1);
    check_seq(1'b1, 1'b1, 1'b0, 30);

    // Idle arrives exactly at the timeout edge
    i_swReset = 1'b1;
    tick();
    i_swReset = 1'b0;
    chk("co_timeout_S", 32'(r_timeout), 32'd0);
    for (int k = 1; k <= 63; k++) tick();
    chk("co_units_S63", 32'(r_unitReset), 32'h0);
    i_unitIdle = 4'b1111;
    tick();
    chk("co_units_S64", 32'(r_unitReset), 32'hf);
    chk("co_timeout_S64", 32'(r_timeout), 32'd0);
    check_seq(1'b0, 1'b0, 1'b0, 30);

    // Async reset during a partial release
    @(negedge clk1x);
    i_reset = 1'b1;
    repeat (3) tick();
    release_reset();
    check_seq(1'b0, 1'b0, 1'b1, 21);
    #3 i_reset = 1'b1;
    #1;
    chk("mid_units", 32'(r_unitReset), 32'hf);
    chk("mid_ready", 32'(r_ready), 32'd0);
    chk("mid_busy", 32'(r_busy), 32'd1);
    chk("mid_u1_unit", 32'(unit1), 32'd1);
    repeat (2) tick();
    release_reset();
    check_seq(1'b0, 1'b0, 1'b1, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
